// File: rtl/cpu_writeback_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cpu_writeback_fifo
// Purpose  : Multi-source writeback FIFO. All accepted source results are
//            written in one cycle, in ascending source order. Each result is
//            formatted (byte/half/word extraction plus sign or zero
//            extension) before it is stored. The CPU pops the head entry.
// Options  : CPU_WB_FIFO_STATS_EN - enables the peak-occupancy and
//            stall-cycle statistics registers.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_writeback_fifo #(
  parameter int DEPTH   = 8,
  parameter int NUM_SRC = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [32*NUM_SRC-1:0] src_data,
  input  logic [10*NUM_SRC-1:0] src_tag,
  output logic [NUM_SRC-1:0]    src_ready,
  input  logic                  cpu_ready,
  output logic                  out_valid,
  output logic [4:0]            out_dest_reg,
  output logic [31:0]           out_data,
  output logic                  fmt_error,
  output logic [6:0]            stat_peak,
  output logic [15:0]           stat_stall
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_NSRC  = c_CW'(NUM_SRC);

  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_CW-1:0] r_count;
  logic            r_ready;
  logic            r_fmt_error;

  logic [31:0]     r_data_mem [DEPTH];
  logic [4:0]      r_dest_mem [DEPTH];

  logic [NUM_SRC-1:0] w_accept;
  logic [c_PW-1:0]    w_slot [NUM_SRC];
  logic [31:0]        w_fmt_data [NUM_SRC];
  logic [NUM_SRC-1:0] w_fmt_bad;
  logic [c_CW-1:0]    w_push_cnt;
  logic               w_pop;
  logic [c_CW-1:0]    w_count_next;
  logic               w_ready_next;

  // Extract the addressed byte/half/word and extend it; bit 32 flags a bad code.
  function automatic logic [32:0] f_format(input logic [31:0] d, input logic [9:0] t);
    logic [7:0]  v_b;
    logic [15:0] v_h;
    logic        v_ext;
    logic [32:0] v_r;
    v_b   = d[{t[6:5], 3'b000} +: 8];
    v_h   = t[6] ? d[31:16] : d[15:0];
    v_ext = ~t[9];
    v_r   = '0;
    case (t[8:5])
      4'b0000, 4'b0001, 4'b0010, 4'b0011:
        v_r = {1'b0, {24{v_ext & v_b[7]}}, v_b};
      4'b0100, 4'b0110:
        v_r = {1'b0, {16{v_ext & v_h[15]}}, v_h};
      4'b1000:
        v_r = {1'b0, d};
      default:
        v_r = {1'b1, 32'h0};
    endcase
    return v_r;
  endfunction

  // Accepted sources get consecutive slots after the write pointer, lowest index first.
  always_comb begin
    w_push_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_accept[i]   = src_valid[i] & r_ready;
      w_slot[i]     = r_wr_ptr + w_push_cnt[c_PW-1:0];
      {w_fmt_bad[i], w_fmt_data[i]} = f_format(src_data[32*i +: 32], src_tag[10*i +: 10]);
      if (w_accept[i]) begin
        w_push_cnt = w_push_cnt + c_ONE;
      end
    end
    w_pop        = (r_count != '0) & cpu_ready;
    w_count_next = r_count + w_push_cnt - (w_pop ? c_ONE : '0);
    w_ready_next = (c_DEPTH - w_count_next) >= c_NSRC;
  end

  // Pointer, occupancy, shared ready and sticky format-error state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_ready     <= 1'b1;
      r_fmt_error <= 1'b0;
    end else begin
      r_rd_ptr    <= r_rd_ptr + (w_pop ? c_PW'(1) : '0);
      r_wr_ptr    <= r_wr_ptr + w_push_cnt[c_PW-1:0];
      r_count     <= w_count_next;
      r_ready     <= w_ready_next;
      r_fmt_error <= r_fmt_error | (|(w_accept & w_fmt_bad));
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_accept[i]) begin
        r_data_mem[w_slot[i]] <= w_fmt_data[i];
        r_dest_mem[w_slot[i]] <= src_tag[10*i +: 5];
      end
    end
  end

  assign src_ready    = {NUM_SRC{r_ready}};
  assign out_valid    = (r_count != '0);
  // Gate head outputs so stale array contents never show while empty or in reset.
  assign out_dest_reg = out_valid ? r_dest_mem[r_rd_ptr] : 5'd0;
  assign out_data     = out_valid ? r_data_mem[r_rd_ptr] : 32'd0;
  assign fmt_error    = r_fmt_error;

`ifdef CPU_WB_FIFO_STATS_EN
  logic [6:0]  r_stat_peak;
  logic [15:0] r_stat_stall;

  // Track peak occupancy and saturating count of cycles with sources blocked.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_peak  <= '0;
      r_stat_stall <= '0;
    end else begin
      if (7'(r_count) > r_stat_peak) begin
        r_stat_peak <= 7'(r_count);
      end
      if (!r_ready && (r_stat_stall != 16'hFFFF)) begin
        r_stat_stall <= r_stat_stall + 16'd1;
      end
    end
  end

  assign stat_peak  = r_stat_peak;
  assign stat_stall = r_stat_stall;
`else
  assign stat_peak  = 7'd0;
  assign stat_stall = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_writeback_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_writeback_fifo
// Purpose  : Self-checking bench for cpu_writeback_fifo (DEPTH=8, NUM_SRC=3)
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_writeback_fifo;

  localparam int c_DEPTH = 8;
  localparam int c_NSRC  = 3;

  logic        clock;
  logic        reset_n;
  logic [2:0]  src_valid;
  logic [95:0] src_data;
  logic [29:0] src_tag;
  logic [2:0]  src_ready;
  logic        cpu_ready;
  logic        out_valid;
  logic [4:0]  out_dest_reg;
  logic [31:0] out_data;
  logic        fmt_error;
  logic [6:0]  stat_peak;
  logic [15:0] stat_stall;

  cpu_writeback_fifo #(.DEPTH(c_DEPTH), .NUM_SRC(c_NSRC)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_tag      (src_tag),
    .src_ready    (src_ready),
    .cpu_ready    (cpu_ready),
    .out_valid    (out_valid),
    .out_dest_reg (out_dest_reg),
    .out_data     (out_data),
    .fmt_error    (fmt_error),
    .stat_peak    (stat_peak),
    .stat_stall   (stat_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [36:0] m_q [$];   // {dest[4:0], data[31:0]}
  bit          m_ready;
  bit          m_fmt;
  int          m_peak;
  int          m_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_fmt(input logic [31:0] d, input logic [9:0] t, output bit bad);
    int unsigned code;
    logic [31:0] v;
    code = 32'(t[8:5]);
    bad  = 1'b0;
    v    = 32'h0;
    if (code <= 3) begin
      v = (d >> (8 * code)) & 32'hFF;
      if (!t[9] && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (code == 4 || code == 6) begin
      v = (d >> ((code == 6) ? 16 : 0)) & 32'hFFFF;
      if (!t[9] && v >= 32768) v = v | 32'hFFFF_0000;
    end else if (code == 8) begin
      v = d;
    end else begin
      bad = 1'b1;
    end
    return v;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_ready = 1'b1;
    m_fmt   = 1'b0;
    m_peak  = 0;
    m_stall = 0;
  endtask

  task automatic model_cycle(input logic [2:0] v, input logic [95:0] d, input logic [29:0] t, input logic cr);
    int  sz;
    bit  bad;
    logic [31:0] fd;
    sz = m_q.size();
    if (sz > m_peak) m_peak = sz;
    if (!m_ready && m_stall < 16'hFFFF) m_stall++;
    if (m_ready) begin
      for (int i = 0; i < c_NSRC; i++) begin
        if (v[i]) begin
          fd = ref_fmt(d[32*i +: 32], t[10*i +: 10], bad);
          if (bad) m_fmt = 1'b1;
          m_q.push_back({t[10*i +: 5], fd});
        end
      end
    end
    if (sz > 0 && cr) void'(m_q.pop_front());
    m_ready = (c_DEPTH - m_q.size()) >= c_NSRC;
  endtask

  task automatic check_outputs();
    check("occupancy_le_depth", 32'(m_q.size() <= c_DEPTH), 32'd1);
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("out_data", out_data, m_q[0][31:0]);
      check("out_dest_reg", 32'(out_dest_reg), 32'(m_q[0][36:32]));
    end
    check("src_ready", 32'(src_ready), m_ready ? 32'd7 : 32'd0);
    check("fmt_error", 32'(fmt_error), 32'(m_fmt));
`ifdef CPU_WB_FIFO_STATS_EN
    check("stat_peak", 32'(stat_peak), 32'(m_peak));
    check("stat_stall", 32'(stat_stall), 32'(m_stall));
`else
    check("stat_peak_off", 32'(stat_peak), 32'd0);
    check("stat_stall_off", 32'(stat_stall), 32'd0);
`endif
  endtask

  // One clock: drive inputs, advance model at the edge, check after settling.
  task automatic step(input logic [2:0] v, input logic [95:0] d, input logic [29:0] t, input logic cr);
    src_valid = v;
    src_data  = d;
    src_tag   = t;
    cpu_ready = cr;
    @(posedge clock);
    model_cycle(v, d, t, cr);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic push1(input logic [31:0] d, input logic [9:0] t, input logic cr);
    step(3'b001, {64'h0, d}, {20'h0, t}, cr);
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * c_DEPTH && m_q.size() != 0; k++) step(3'b000, '0, '0, 1'b1);
    check("drained", 32'(out_valid), 32'd0);
  endtask

  function automatic logic [9:0] mk_tag(input logic u, input logic [3:0] code, input logic [4:0] rd);
    return {u, code, rd};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] codes [8];
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b1000, 4'b0101};

    reset_n   = 1'b0;
    src_valid = '0;
    src_data  = '0;
    src_tag   = '0;
    cpu_ready = 1'b0;
    model_clear();
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dest", 32'(out_dest_reg), 32'd0);
    check("rst_src_ready", 32'(src_ready), 32'd7);
    check("rst_fmt_error", 32'(fmt_error), 32'd0);
    check("rst_stats", {9'h0, stat_peak, stat_stall}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single word push
    push1(32'h1234_5678, mk_tag(1'b0, 4'b1000, 5'd5), 1'b0);
    check("single_data", out_data, 32'h1234_5678);
    check("single_dest", 32'(out_dest_reg), 32'd5);
    drain();

    // Byte lane 3 signed and unsigned
    push1(32'h8000_0000, mk_tag(1'b0, 4'b0011, 5'd7), 1'b0);
    check("ext_signed", out_data, 32'hFFFF_FF80);
    step(3'b000, '0, '0, 1'b1);
    push1(32'h8000_0000, mk_tag(1'b1, 4'b0011, 5'd7), 1'b0);
    check("ext_unsigned", out_data, 32'h0000_0080);
    drain();

    // Simultaneous push from all three sources
    step(3'b111, {32'hC, 32'hB, 32'hA},
         {mk_tag(1'b0, 4'b1000, 5'd3), mk_tag(1'b0, 4'b1000, 5'd2), mk_tag(1'b0, 4'b1000, 5'd1)}, 1'b0);
    check("simul_first", 32'(out_dest_reg), 32'd1);
    step(3'b000, '0, '0, 1'b1);
    check("simul_second", 32'(out_dest_reg), 32'd2);
    step(3'b000, '0, '0, 1'b1);
    check("simul_third", 32'(out_dest_reg), 32'd3);
    drain();

    // Backpressure
    for (int k = 0; k < 6; k++) push1(32'h100 + 32'(k), mk_tag(1'b0, 4'b1000, 5'(k)), 1'b0);
    check("bp_ready_low", 32'(src_ready), 32'd0);
    push1(32'hDEAD_BEEF, mk_tag(1'b0, 4'b1000, 5'd31), 1'b0);
    step(3'b000, '0, '0, 1'b1);
    check("bp_ready_back", 32'(src_ready), 32'd7);
`ifdef CPU_WB_FIFO_STATS_EN
    check("bp_peak6", 32'(stat_peak), 32'd6);
    check("bp_stall_nz", 32'(stat_stall != 0), 32'd1);
`endif
    drain();

    // Illegal size code
    push1(32'hFFFF_FFFF, mk_tag(1'b0, 4'b0101, 5'd9), 1'b0);
    check("illegal_data", out_data, 32'h0);
    check("illegal_flag", 32'(fmt_error), 32'd1);
    drain();

    // Wrap: push/pop pairs
    push1(32'h5555_0000, mk_tag(1'b1, 4'b1000, 5'd0), 1'b0);
    for (int k = 0; k < 20; k++)
      push1($urandom, mk_tag(1'($urandom), codes[$urandom_range(0, 6)], 5'($urandom)), 1'b1);

    // Reset mid-stream
    for (int k = 0; k < 3; k++) push1($urandom, mk_tag(1'b0, 4'b1000, 5'(k)), 1'b0);
    src_valid = '0;
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_src_ready", 32'(src_ready), 32'd7);
    check("midrst_fmt", 32'(fmt_error), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    model_clear();
    step(3'b000, '0, '0, 1'b1);
    check("postrst_empty", 32'(out_valid), 32'd0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      logic [95:0] d;
      logic [29:0] t;
      d = {$urandom, $urandom, $urandom};
      for (int i = 0; i < c_NSRC; i++)
        t[10*i +: 10] = mk_tag(1'($urandom), codes[$urandom_range(0, (k > 300) ? 7 : 6)], 5'($urandom));
      step(3'($urandom_range(0, 7)), d, t, ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_writeback_fifo.md
CPU_WRITEBACK_FIFO -- requirements
Module: cpu_writeback_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8; FIFO entries; power of two, 4..64.
REQ-002 SHALL have parameter NUM_SRC, default 3; number of result sources (dcache, decoder, divider, ...); 1..4, and NUM_SRC <= DEPTH.
REQ-003 SHALL have ports `clock`, input, 1 bit; the single clock.
REQ-004 SHALL have port `reset_n`, input, 1 bit; asynchronous, active-low reset.
REQ-005 SHALL have port `src_valid`, input, NUM_SRC bits; per-source result valid.
REQ-006 SHALL have port `src_data`, input, 32*NUM_SRC bits; raw 32-bit word per source; source i occupies bits [32i+31:32i].
REQ-007 SHALL have port `src_tag`, input, 10*NUM_SRC bits; per source: [9] unsigned flag, [8:5] size/lane code, [4:0] destination register.
REQ-008 SHALL have port `src_ready`, output, NUM_SRC bits; per-source permission to present a result.
REQ-009 SHALL have port `cpu_ready`, input, 1 bit; the CPU consumes the head entry this cycle.
REQ-010 SHALL have port `out_valid`, output, 1 bit; the head entry is valid.
REQ-011 SHALL have port `out_dest_reg`, output, 5 bits; destination register of the head entry.
REQ-012 SHALL have port `out_data`, output, 32 bits; formatted data of the head entry.
REQ-013 SHALL have port `fmt_error`, output, 1 bit; sticky flag, set on an illegal size code.
REQ-014 SHALL have port `stat_peak`, output, 7 bits; peak occupancy (see Configuration).
REQ-015 SHALL have port `stat_stall`, output, 16 bits; count of cycles in which `src_ready` was low (see Configuration).

Function
REQ-016 SHALL implement a circular buffer: read pointer, write pointer and occupancy count; pointers wrap modulo DEPTH.
REQ-017 SHALL drive all `src_ready` bits from one shared register, set when free slots (DEPTH - count) >= NUM_SRC after this cycle's push and pop.
REQ-018 SHALL ensure that no accepted push ever overflows; a valid asserted while ready is low is a protocol violation and its data is ignored.
REQ-019 SHALL accept every source with src_valid=1 in the same cycle, written in ascending source-index order at consecutive slots.
REQ-020 SHALL pop the head entry when out_valid=1 and cpu_ready=1; cpu_ready while empty has no effect.
REQ-021 SHALL allow push and pop in the same cycle; count_next = count + pushes - pop.
REQ-022 SHALL make an entry pushed into an empty FIFO visible on the outputs in the following cycle; there is no combinational bypass.
REQ-023 SHALL drive out_valid high exactly when count != 0, and drive out_dest_reg and out_data from the head slot.
REQ-024 SHALL format data before storage, using the size/lane codes below.
  - Codes 0000-0011: byte lanes 0-3.
  - Codes 0100 and 0110: half-word lanes 0 and 1.
  - Code 1000: full word.
REQ-025 SHALL sign-extend bytes and half-words when tag[9]=0 and zero-extend them when tag[9]=1; tag[9] is ignored for the word code.
REQ-026 SHALL store data 0 for any other size code and set fmt_error, which stays set until reset.

Reset
REQ-027 SHALL, while reset_n=0, clear both pointers, count, fmt_error, stat_peak and stat_stall, and drive out_valid=0, out_dest_reg=0 and src_ready=all ones.
REQ-028 SHALL, when reset is asserted mid-operation, discard all entries and take effect immediately, without waiting for a clock edge.
REQ-029 SHALL leave stored data contents unreset.

Configuration
REQ-030 SHALL, with `CPU_WB_FIFO_STATS_EN` defined, update stat_peak every cycle to max(stat_peak, count).
REQ-031 SHALL, with `CPU_WB_FIFO_STATS_EN` defined, increment stat_stall on each cycle with src_ready=0, saturating at 16'hFFFF.
REQ-032 SHALL, without `CPU_WB_FIFO_STATS_EN`, tie stat_peak and stat_stall to 0 and synthesise no statistics registers.

Verification
REQ-033 SHALL cover single push: DEPTH=8, src0 pushes word 32'h12345678, reg 5 -> next cycle out_valid=1, out_data=32'h12345678, out_dest_reg=5.
REQ-034 SHALL cover extension: byte lane 3 on data 32'h80000000, signed -> 32'hFFFFFF80; the same with tag[9]=1 -> 32'h00000080.
REQ-035 SHALL cover simultaneous push: src2, src0 and src1 valid in one cycle (regs 3, 1, 2) -> pops return regs 1, 2, 3 in that order.
REQ-036 SHALL cover backpressure: with cpu_ready=0, push until count=6 -> src_ready=0; one pop -> src_ready=1 the next cycle; occupancy never exceeds 8.
REQ-037 SHALL cover wrap and reset: 20 push/pop pairs wrap the pointers with data intact; reset_n low mid-stream -> out_valid=0 immediately, and after release the FIFO is empty.
REQ-038 SHALL cover illegal code and statistics: size code 0101 -> out_data=0 and fmt_error=1; with the macro, after the backpressure test stat_peak=6 and stat_stall>0.
